ring_monitor: RTL and testbench

RING_MONITOR -- requirements
Module: ring_monitor

---
 rtl/ring_pkg.sv | 18 +
 rtl/onehot_enc.sv | 23 ++
 rtl/ring_monitor.sv | 130 +++++++++++++
 tb/tb_ring_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and constants for the ring counter monitor
package ring_pkg;

  localparam int RING_W       = 4;
  localparam int LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  // Expected successor of a ring sample: rotate left by one position
  function automatic logic [RING_W-1:0] rotl1(input logic [RING_W-1:0] v);
    return {v[RING_W-2:0], v[RING_W-1]};
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - one-hot to binary encoder with exact one-hot check
module onehot_enc
  import ring_pkg::*;
(
  input  logic [RING_W-1:0] vec_i,
  output logic [1:0]        idx_o,
  output logic              valid_o
);

  // Only the four exact one-hot patterns are valid; anything else reports index 0
  always_comb begin
    idx_o   = 2'd0;
    valid_o = 1'b1;
    case (vec_i)
      4'b0001: idx_o = 2'd0;
      4'b0010: idx_o = 2'd1;
      4'b0100: idx_o = 2'd2;
      4'b1000: idx_o = 2'd3;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - lock/error monitor for an upstream one-hot ring counter
module ring_monitor
  import ring_pkg::*;
#(
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [RING_W-1:0] Ring_in,
  input  logic              Clear_err,
  output logic [1:0]        Phase,
  output logic              Phase_valid,
  output logic              Lock,
  output logic [7:0]        Rotation_count,
  output logic              Err_sticky,
  output logic [3:0]        Err_count
);

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_CNT);

  logic [RING_W-1:0] ring_q;
  logic [1:0]        phase_q;
  logic              phase_valid_q;
  state_e            state_q, state_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic              lock_q;
  logic [7:0]        rot_q, rot_d;
  logic              err_sticky_q, err_sticky_d;
  logic [3:0]        err_cnt_q, err_cnt_d;

  logic [1:0]        enc_idx;
  logic              enc_valid;
  logic              legal;
  logic              err_evt;

  onehot_enc u_enc (
    .vec_i   (Ring_in),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign legal = enc_valid && (Ring_in == rotl1(ring_q));

  // Lock-acquisition FSM: count consecutive legal advances, drop out on any bad sample
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_evt    = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (legal) begin
          good_cnt_d = 4'd1;
          state_d    = (LOCK_CNT4 == 4'd1) ? LOCKED : ACQUIRE;
        end else begin
          good_cnt_d = 4'd0;
        end
      end
      ACQUIRE: begin
        if (legal) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_d == LOCK_CNT4) state_d = LOCKED;
        end else begin
          state_d    = UNLOCKED;
          good_cnt_d = 4'd0;
          err_evt    = 1'b1;
        end
      end
      LOCKED: begin
        if (!legal) begin
          state_d    = UNLOCKED;
          good_cnt_d = 4'd0;
          err_evt    = 1'b1;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        good_cnt_d = 4'd0;
      end
    endcase
  end

  // Error bookkeeping and rotation counting; a coincident error overrides a clear
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    rot_d        = rot_q;
    if (err_evt) begin
      err_sticky_d = 1'b1;
      if (Clear_err)                err_cnt_d = 4'd1;
      else if (err_cnt_q != 4'd15)  err_cnt_d = err_cnt_q + 4'd1;
    end else if (Clear_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = 4'd0;
    end
    if (legal && (state_q == LOCKED) && (Ring_in == 4'b0001)) rot_d = rot_q + 8'd1;
  end

  // State registers; reset places the monitor in step with the upstream counter's 0001
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ring_q        <= 4'b0001;
      phase_q       <= 2'd0;
      phase_valid_q <= 1'b1;
      state_q       <= UNLOCKED;
      good_cnt_q    <= 4'd0;
      lock_q        <= 1'b0;
      rot_q         <= 8'd0;
      err_sticky_q  <= 1'b0;
      err_cnt_q     <= 4'd0;
    end else begin
      ring_q        <= Ring_in;
      if (enc_valid) phase_q <= enc_idx;
      phase_valid_q <= enc_valid;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      lock_q        <= (state_d == LOCKED);
      rot_q         <= rot_d;
      err_sticky_q  <= err_sticky_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign Phase          = phase_q;
  assign Phase_valid    = phase_valid_q;
  assign Lock           = lock_q;
  assign Rotation_count = rot_q;
  assign Err_sticky     = err_sticky_q;
  assign Err_count      = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - directed self-checking bench for ring_monitor
module tb_ring_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Ring_in = 4'b0001;
  logic       Clear_err = 1'b0;
  logic [1:0] Phase;
  logic       Phase_valid;
  logic       Lock;
  logic [7:0] Rotation_count;
  logic       Err_sticky;
  logic [3:0] Err_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] cur = 4'b0001;

  ring_monitor #(.LOCK_CNT(4)) dut (
    .Clock          (clk),
    .Reset          (rst),
    .Ring_in        (Ring_in),
    .Clear_err      (Clear_err),
    .Phase          (Phase),
    .Phase_valid    (Phase_valid),
    .Lock           (Lock),
    .Rotation_count (Rotation_count),
    .Err_sticky     (Err_sticky),
    .Err_count      (Err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic step(input logic [3:0] r, input logic clr);
    @(negedge clk);
    Ring_in   = r;
    Clear_err = clr;
    cur       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    step(rotl(cur), 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Ring_in = 4'b0001;
    cur = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", Phase); end
    checks++; if (Phase_valid !== 1'b1) begin errors++; $display("FAIL reset_pvalid got=%0b exp=1", Phase_valid); end
    checks++; if (Lock !== 1'b0) begin errors++; $display("FAIL reset_lock got=%0b exp=0", Lock); end
    checks++; if (Rotation_count !== 8'd0) begin errors++; $display("FAIL reset_rot got=%0d exp=0", Rotation_count); end
    checks++; if (Err_sticky !== 1'b0 || Err_count !== 4'd0) begin errors++; $display("FAIL reset_err got=%0b/%0d exp=0/0", Err_sticky, Err_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_acquire();
    adv(); adv(); adv();
    checks++; if (Lock !== 1'b0) begin errors++; $display("FAIL lock_after3 got=%0b exp=0", Lock); end
    adv();
    checks++; if (Lock !== 1'b1) begin errors++; $display("FAIL lock_after4 got=%0b exp=1", Lock); end
    checks++; if (Phase !== 2'd0) begin errors++; $display("FAIL lock_phase got=%0d exp=0", Phase); end
    checks++; if (Rotation_count !== 8'd0) begin errors++; $display("FAIL lock_rot0 got=%0d exp=0", Rotation_count); end
    adv(); adv();
    checks++; if (Phase !== 2'd2) begin errors++; $display("FAIL rot_midphase got=%0d exp=2", Phase); end
    adv(); adv();
    checks++; if (Rotation_count !== 8'd1) begin errors++; $display("FAIL rot_first got=%0d exp=1", Rotation_count); end
  endtask

  task automatic test_stall();
    adv(); adv();
    checks++; if (Lock !== 1'b1) begin errors++; $display("FAIL stall_pre_lock got=%0b exp=1", Lock); end
    step(cur, 1'b0);
    checks++; if (Lock !== 1'b0) begin errors++; $display("FAIL stall_lock got=%0b exp=0", Lock); end
    checks++; if (Err_sticky !== 1'b1 || Err_count !== 4'd1) begin errors++; $display("FAIL stall_err got=%0b/%0d exp=1/1", Err_sticky, Err_count); end
    checks++; if (Phase !== 2'd2) begin errors++; $display("FAIL stall_phase got=%0d exp=2", Phase); end
  endtask

  task automatic test_multihot();
    adv(); adv(); adv(); adv();
    checks++; if (Lock !== 1'b1 || Rotation_count !== 8'd1) begin errors++; $display("FAIL relock got=%0b/%0d exp=1/1", Lock, Rotation_count); end
    step(4'b0110, 1'b0);
    checks++; if (Phase_valid !== 1'b0) begin errors++; $display("FAIL mh_pvalid got=%0b exp=0", Phase_valid); end
    checks++; if (Phase !== 2'd2) begin errors++; $display("FAIL mh_phase got=%0d exp=2", Phase); end
    checks++; if (Lock !== 1'b0 || Err_count !== 4'd2) begin errors++; $display("FAIL mh_lock_err got=%0b/%0d exp=0/2", Lock, Err_count); end
    step(4'b0001, 1'b0);
    checks++; if (Err_count !== 4'd2 || Phase_valid !== 1'b1) begin errors++; $display("FAIL unlocked_bad got=%0d/%0b exp=2/1", Err_count, Phase_valid); end
  endtask

  task automatic test_saturate_clear();
    step(cur, 1'b1);
    checks++; if (Err_count !== 4'd0 || Err_sticky !== 1'b0) begin errors++; $display("FAIL clear1 got=%0d/%0b exp=0/0", Err_count, Err_sticky); end
    for (int i = 0; i < 20; i++) begin
      adv();
      step(cur, 1'b0);
    end
    checks++; if (Err_count !== 4'd15 || Err_sticky !== 1'b1) begin errors++; $display("FAIL saturate got=%0d/%0b exp=15/1", Err_count, Err_sticky); end
    step(cur, 1'b1);
    checks++; if (Err_count !== 4'd0 || Err_sticky !== 1'b0) begin errors++; $display("FAIL clear2 got=%0d/%0b exp=0/0", Err_count, Err_sticky); end
    adv();
    step(cur, 1'b1);
    checks++; if (Err_count !== 4'd1 || Err_sticky !== 1'b1) begin errors++; $display("FAIL clear_vs_err got=%0d/%0b exp=1/1", Err_count, Err_sticky); end
    step(cur, 1'b0);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst = 1'b1; Ring_in = 4'b0001; cur = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    adv(); adv(); adv(); adv();
    for (int i = 0; i < 255; i++) begin
      adv(); adv(); adv(); adv();
    end
    checks++; if (Rotation_count !== 8'd255 || Lock !== 1'b1) begin errors++; $display("FAIL rot255 got=%0d/%0b exp=255/1", Rotation_count, Lock); end
    adv(); adv(); adv(); adv();
    checks++; if (Rotation_count !== 8'd0) begin errors++; $display("FAIL rot_wrap got=%0d exp=0", Rotation_count); end
  endtask

  task automatic test_reset_mid_acquire();
    step(cur, 1'b0);
    adv(); adv();
    checks++; if (Lock !== 1'b0 || Err_count !== 4'd1 || Phase !== 2'd2) begin errors++; $display("FAIL pre_rst got=%0b/%0d/%0d exp=0/1/2", Lock, Err_count, Phase); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (Phase !== 2'd0 || Phase_valid !== 1'b1) begin errors++; $display("FAIL async_rst_phase got=%0d/%0b exp=0/1", Phase, Phase_valid); end
    checks++; if (Err_count !== 4'd0 || Err_sticky !== 1'b0 || Rotation_count !== 8'd0) begin errors++; $display("FAIL async_rst_cnt got=%0d/%0b/%0d exp=0/0/0", Err_count, Err_sticky, Rotation_count); end
    Ring_in = 4'b0001; cur = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    adv(); adv(); adv();
    checks++; if (Lock !== 1'b0) begin errors++; $display("FAIL post_rst_3 got=%0b exp=0", Lock); end
    adv();
    checks++; if (Lock !== 1'b1 || Rotation_count !== 8'd0) begin errors++; $display("FAIL post_rst_4 got=%0b/%0d exp=1/0", Lock, Rotation_count); end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_stall();
    test_multihot();
    test_saturate_clear();
    test_wrap();
    test_reset_mid_acquire();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
